// File: rtl/ddr_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_rd_arbiter
//  Purpose  : Shares one DDR read-request channel between two requesters
//             (0 = PDU data mover, 1 = secondary client). Round-robin grant,
//             credit-based reservation of response-FIFO space, and in-order
//             steering of response beats back to the issuing requester.
//  Ports    : clk, rst                      - clock, sync active-high reset
//             req{0,1}_data/len/valid/ready - request inputs, ready = grant
//             ddr_rd_req_data/valid         - registered issued request
//             ddr_rd_req_almost_full        - DDR request backpressure
//             ddr_rd_resp_data/valid/ready  - DDR response beats
//             resp{0,1}_data/valid/ready    - routed response beats
//             credits_avail                 - free response credits
//             stat_grant0/1, stat_spurious  - statistics counters
//  Options  : DDR_RD_ARB_STATS_EN - build the statistics counters; when
//             undefined the stat_* outputs are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module ddr_rd_arbiter #(
  parameter int REQ_W       = 64,
  parameter int LEN_W       = 6,
  parameter int CREDITS     = 448,
  parameter int ORDER_DEPTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REQ_W-1:0]   req0_data,
  input  logic [LEN_W-1:0]   req0_len,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [REQ_W-1:0]   req1_data,
  input  logic [LEN_W-1:0]   req1_len,
  input  logic               req1_valid,
  output logic               req1_ready,
  output logic [REQ_W-1:0]   ddr_rd_req_data,
  output logic               ddr_rd_req_valid,
  input  logic               ddr_rd_req_almost_full,
  input  logic [511:0]       ddr_rd_resp_data,
  input  logic               ddr_rd_resp_valid,
  output logic               ddr_rd_resp_ready,
  output logic [511:0]       resp0_data,
  output logic               resp0_valid,
  input  logic               resp0_ready,
  output logic [511:0]       resp1_data,
  output logic               resp1_valid,
  input  logic               resp1_ready,
  output logic [15:0]        credits_avail,
  output logic [31:0]        stat_grant0,
  output logic [31:0]        stat_grant1,
  output logic [31:0]        stat_spurious
);

  localparam int                c_AW       = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
  localparam logic [c_AW:0]     c_DEPTH    = (c_AW+1)'(ORDER_DEPTH);
  localparam logic [c_AW:0]     c_CNT_ONE  = (c_AW+1)'(1);
  localparam logic [c_AW-1:0]   c_PTR_ONE  = c_AW'(1);
  localparam logic [15:0]       c_CREDITS  = 16'(CREDITS);
  localparam logic [LEN_W-1:0]  c_LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0]  c_LEN_ZERO = '0;

  // Order FIFO: which requester owns each outstanding request, and its length
  logic [ORDER_DEPTH-1:0] r_ord_id;
  logic [LEN_W-1:0]       r_ord_len [ORDER_DEPTH];
  logic [c_AW-1:0]        r_wr_ptr;
  logic [c_AW-1:0]        r_rd_ptr;
  logic [c_AW:0]          r_count;
  logic [LEN_W-1:0]       r_beats_done;   // beats already delivered for the head
  logic [15:0]            r_credits;
  logic                   r_last;         // 1: requester 1 won most recently
  logic [REQ_W-1:0]       r_req_data;
  logic                   r_req_valid;

  logic                   w_fifo_full;
  logic                   w_head_vld;
  logic                   w_head_id;
  logic [LEN_W-1:0]       w_head_len;
  logic                   w_head_rdy;
  logic                   w_can_issue;
  logic                   w_elig0;
  logic                   w_elig1;
  logic                   w_gnt0;
  logic                   w_gnt1;
  logic [LEN_W-1:0]       w_gnt_len;
  logic [REQ_W-1:0]       w_gnt_data;
  logic                   w_push;
  logic                   w_beat;
  logic                   w_pop;
  logic [16:0]            w_cred_next;

  assign w_fifo_full = (r_count == c_DEPTH);
  assign w_head_vld  = (r_count != '0);
  assign w_head_id   = r_ord_id[r_rd_ptr];
  assign w_head_len  = r_ord_len[r_rd_ptr];

  // Grants are suppressed while in reset so ready never pulses then
  assign w_can_issue = !rst && !w_fifo_full && !ddr_rd_req_almost_full;
  assign w_elig0     = w_can_issue && req0_valid && (16'(req0_len) <= r_credits);
  assign w_elig1     = w_can_issue && req1_valid && (16'(req1_len) <= r_credits);

  // With both eligible, the requester that did not win last time goes
  assign w_gnt0      = w_elig0 && (!w_elig1 || r_last);
  assign w_gnt1      = w_elig1 && (!w_elig0 || !r_last);
  assign req0_ready  = w_gnt0;
  assign req1_ready  = w_gnt1;

  assign w_gnt_len   = w_gnt1 ? req1_len  : req0_len;
  assign w_gnt_data  = w_gnt1 ? req1_data : req0_data;
  // Zero-length requests are acknowledged but never reach DDR
  assign w_push      = (w_gnt0 || w_gnt1) && (w_gnt_len != c_LEN_ZERO);

  assign w_head_rdy  = w_head_id ? resp1_ready : resp0_ready;
  assign w_beat      = w_head_vld && ddr_rd_resp_valid && w_head_rdy;
  assign w_pop       = w_beat && (r_beats_done == (w_head_len - c_LEN_ONE));

  assign resp0_valid = w_head_vld && !w_head_id && ddr_rd_resp_valid;
  assign resp1_valid = w_head_vld &&  w_head_id && ddr_rd_resp_valid;
  assign resp0_data  = resp0_valid ? ddr_rd_resp_data : '0;
  assign resp1_data  = resp1_valid ? ddr_rd_resp_data : '0;
  // With nothing outstanding any arriving beat is accepted and discarded
  assign ddr_rd_resp_ready = w_head_vld ? w_head_rdy : ddr_rd_resp_valid;

  // One extra bit so an underflow shows up as bit 16 set
  assign w_cred_next = {1'b0, r_credits}
                     - (w_push ? 17'(w_gnt_len) : 17'd0)
                     + (w_beat ? 17'd1 : 17'd0);

  assign ddr_rd_req_data  = r_req_data;
  assign ddr_rd_req_valid = r_req_valid;
  assign credits_avail    = r_credits;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_data   <= '0;
      r_req_valid  <= 1'b0;
      r_last       <= 1'b1;
      r_credits    <= c_CREDITS;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_beats_done <= '0;
    end else begin
      r_req_valid <= w_push;
      if (w_push) begin
        r_req_data <= w_gnt_data;
        r_wr_ptr   <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_gnt0 || w_gnt1) begin
        r_last <= w_gnt1;
      end
      r_credits <= w_cred_next[15:0];
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + c_PTR_ONE;
        r_beats_done <= '0;
      end else if (w_beat) begin
        r_beats_done <= r_beats_done + c_LEN_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ord_id[r_wr_ptr]  <= w_gnt1;
      r_ord_len[r_wr_ptr] <= w_gnt_len;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!w_cred_next[16]);
      assert (w_cred_next[15:0] <= c_CREDITS);
    end
  end

`ifdef DDR_RD_ARB_STATS_EN
  logic        w_spurious;
  logic [31:0] r_stat_g0;
  logic [31:0] r_stat_g1;
  logic [31:0] r_stat_sp;

  assign w_spurious = !w_head_vld && ddr_rd_resp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_g0 <= '0;
      r_stat_g1 <= '0;
      r_stat_sp <= '0;
    end else begin
      if (w_push && !w_gnt1) r_stat_g0 <= r_stat_g0 + 32'd1;
      if (w_push &&  w_gnt1) r_stat_g1 <= r_stat_g1 + 32'd1;
      if (w_spurious)        r_stat_sp <= r_stat_sp + 32'd1;
    end
  end

  assign stat_grant0   = r_stat_g0;
  assign stat_grant1   = r_stat_g1;
  assign stat_spurious = r_stat_sp;
`else
  assign stat_grant0   = '0;
  assign stat_grant1   = '0;
  assign stat_spurious = '0;
`endif

endmodule
`default_nettype wire
